uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NREQ byte requesters using round-robin arbitration.
- Captures the winning byte and drives the transmitter's level-held Send / Busy handshake to completion.
- Returns a one-cycle acknowledge to the winning requester.
- Includes a watchdog: a transmitter that never raises Busy cannot hang the arbiter.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter and related shared-resource blocks.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_IDLE = 2'b11
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] sel_c_o,
  output logic                 any_c_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  // Explicit modulo keeps the wrap correct when N is not a power of two.
  always_comb begin
    sel_c_o = '0;
    any_c_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_i) + k) % N);
      if (!any_c_o && req_valid_i[idx]) begin
        any_c_o = 1'b1;
        sel_c_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte requesters,
// with a Send/Busy handshake, one-cycle acknowledge and a Busy watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          Req_Valid,
  input  logic [BYTE_W*NREQ-1:0]   Req_Data,
  output logic [NREQ-1:0]          Req_Ack,
  output logic [NREQ-1:0]          Grant,
  output logic [BYTE_W-1:0]        Tx_Data,
  output logic                     Tx_Send,
  input  logic                     Tx_Busy,
  output logic                     Error
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                hold_q, hold_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                send_q, send_d;
  logic                error_q, error_d;

  logic [IW-1:0]       pick_sel;
  logic                pick_any;
  logic [BYTE_W-1:0]   req_bytes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_bytes[g] = Req_Data[g*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req_valid_i (Req_Valid),
    .ptr_i       (ptr_q),
    .sel_c_o     (pick_sel),
    .any_c_o     (pick_any)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      hold_q  <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      send_q  <= send_d;
      error_q <= error_d;
    end
  end

  // Next-state and registered-output logic; Ack and Error are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    ack_d   = '0;
    grant_d = grant_q;
    data_d  = data_q;
    send_d  = send_q;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A transmitter still busy from a previous byte or another user blocks new grants.
        if (pick_any && !Tx_Busy) begin
          sel_d           = pick_sel;
          data_d          = req_bytes[pick_sel];
          send_d          = 1'b1;
          grant_d         = '0;
          grant_d[pick_sel] = 1'b1;
          timer_d         = TW'(TIMEOUT - 1);
          state_d         = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        // Busy takes priority over an expiring timer.
        if (Tx_Busy) begin
          send_d       = 1'b0;
          ack_d[sel_q] = 1'b1;
          hold_d       = 1'b1;
          state_d      = WAIT_IDLE;
        end else if (timer_q == '0) begin
          send_d  = 1'b0;
          error_d = 1'b1;
          hold_d  = 1'b1;
          state_d = WAIT_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      WAIT_IDLE: begin
        // hold skips one Busy sample to cover the transmitter's Send input register.
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (!Tx_Busy) begin
          grant_d = '0;
          ptr_d   = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Req_Ack = ack_q;
  assign Grant   = grant_q;
  assign Tx_Data = data_q;
  assign Tx_Send = send_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a one-bit-per-clock 8N1 transmitter model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 8;

  logic              Clk;
  logic              Reset;
  logic [NREQ-1:0]   Req_Valid;
  logic [8*NREQ-1:0] Req_Data;
  logic [NREQ-1:0]   Req_Ack;
  logic [NREQ-1:0]   Grant;
  logic [7:0]        Tx_Data;
  logic              Tx_Send;
  logic              Tx_Busy;
  logic              Error;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit drop_on_ack = 1'b1;
  bit mdl_en      = 1'b1;
  logic force_busy = 1'b0;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_Valid (Req_Valid),
    .Req_Data  (Req_Data),
    .Req_Ack   (Req_Ack),
    .Grant     (Grant),
    .Tx_Data   (Tx_Data),
    .Tx_Send   (Tx_Send),
    .Tx_Busy   (Tx_Busy),
    .Error     (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Transmitter model: Send sampled through one register, one line bit per clock,
  // Busy held until the stop bit is done and the sampled Send is low.
  logic       m_send_r = 1'b0;
  logic       m_busy   = 1'b0;
  logic [3:0] m_bit    = '0;
  logic [9:0] m_acc    = '0;
  logic [9:0] m_frame  = '0;
  logic [9:0] m_cur;
  assign m_cur   = {1'b1, Tx_Data, 1'b0};
  assign Tx_Busy = mdl_en ? m_busy : force_busy;

  always @(posedge Clk) begin
    if (!mdl_en) begin
      m_send_r <= 1'b0;
      m_busy   <= 1'b0;
      m_bit    <= '0;
    end else begin
      m_send_r <= Tx_Send;
      if (!m_busy) begin
        if (m_send_r) begin
          m_busy <= 1'b1;
          m_bit  <= '0;
        end
      end else if (m_bit < 4'd10) begin
        m_acc[m_bit] <= m_cur[m_bit];
        m_bit        <= m_bit + 4'd1;
      end else if (!m_send_r) begin
        m_busy  <= 1'b0;
        m_frame <= m_acc;
      end
    end
  end

  // Passive monitor: per-requester ack counts and bytes launched on each Send rise.
  int         ack_cnt [NREQ];
  int         err_cnt = 0;
  logic [7:0] send_log [$];
  logic       prev_send = 1'b0;

  initial for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;

  always @(negedge Clk) begin
    for (int i = 0; i < NREQ; i++) if (Req_Ack[i] === 1'b1) ack_cnt[i]++;
    if (Error === 1'b1) err_cnt++;
    if (Tx_Send === 1'b1 && prev_send !== 1'b1) send_log.push_back(Tx_Data);
    prev_send = Tx_Send;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (drop_on_ack) Req_Valid = Req_Valid & ~Req_Ack;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(Grant == '0 && Req_Valid == '0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  int   base_log, base_ack, base_err, cnt, bad;
  bit   fair;

  initial begin
    Reset     = 1'b0;
    Req_Valid = '0;
    Req_Data  = '0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    chk("rst_ack",   32'(Req_Ack), 32'h0);
    chk("rst_grant", 32'(Grant),   32'h0);
    chk("rst_data",  32'(Tx_Data), 32'h0);
    chk("rst_send",  32'(Tx_Send), 32'h0);
    chk("rst_err",   32'(Error),   32'h0);

    // Single request from requester 1.
    base_ack = ack_cnt[1];
    Req_Data  = 32'h0000_A500;
    Req_Valid = 4'b0010;
    step();
    chk("single_send",  32'(Tx_Send), 32'h1);
    chk("single_data",  32'(Tx_Data), 32'hA5);
    chk("single_grant", 32'(Grant),   32'h2);
    drain("single_drain", 60);
    step();
    chk("single_ack_once", 32'(ack_cnt[1] - base_ack), 32'd1);
    chk("single_frame",    32'(m_frame), 32'(10'b1_1010_0101_0));

    // Round robin with all requesters held valid.
    do_reset();
    drop_on_ack = 1'b0;
    base_log = send_log.size();
    base_ack = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    Req_Data  = 32'h1312_1110;
    Req_Valid = 4'b1111;
    cnt = 0;
    while (send_log.size() < base_log + 5 && cnt < 300) begin
      step();
      cnt++;
    end
    Req_Valid = '0;
    chk("rr_five_sends", 32'(cnt < 300), 32'd1);
    drain("rr_drain", 60);
    step();
    if (send_log.size() >= base_log + 5) begin
      chk("rr_byte0", 32'(send_log[base_log+0]), 32'h10);
      chk("rr_byte1", 32'(send_log[base_log+1]), 32'h11);
      chk("rr_byte2", 32'(send_log[base_log+2]), 32'h12);
      chk("rr_byte3", 32'(send_log[base_log+3]), 32'h13);
      chk("rr_byte4", 32'(send_log[base_log+4]), 32'h10);
      fair = 1'b1;
      for (int i = 1; i < 5; i++)
        if (send_log[base_log+i] == send_log[base_log+i-1]) fair = 1'b0;
      chk("rr_no_repeat", 32'(fair), 32'd1);
    end
    chk("rr_acks", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - base_ack), 32'd5);
    drop_on_ack = 1'b1;

    // Watchdog: transmitter never raises Busy.
    mdl_en     = 1'b0;
    force_busy = 1'b0;
    do_reset();
    base_ack  = ack_cnt[0] + ack_cnt[1];
    base_err  = err_cnt;
    Req_Data  = 32'h0000_2120;
    Req_Valid = 4'b0011;
    step();
    chk("to_send",  32'(Tx_Send), 32'h1);
    chk("to_grant", 32'(Grant),   32'h1);
    cnt = 1;
    while (Error !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("to_err_cycle",   32'(cnt),     32'(TIMEOUT + 1));
    chk("to_send_drop",   32'(Tx_Send), 32'h0);
    chk("to_no_ack",      32'(Req_Ack), 32'h0);
    step();
    chk("to_err_pulse",   32'(Error),   32'h0);
    cnt = 0;
    while (Tx_Send !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("to_next_grant",  32'(Grant),   32'h2);
    chk("to_next_data",   32'(Tx_Data), 32'h21);
    chk("to_ack_total",   32'(ack_cnt[0] + ack_cnt[1] - base_ack), 32'd0);
    chk("to_err_total",   32'(err_cnt - base_err), 32'd1);

    // Busy rises exactly when the timer has reached zero.
    Req_Valid = '0;
    do_reset();
    base_err  = err_cnt;
    Req_Data  = 32'h0000_0033;
    Req_Valid = 4'b0001;
    step();
    chk("exp_send", 32'(Tx_Send), 32'h1);
    repeat (TIMEOUT - 1) step();
    chk("exp_pre_err",  32'(Error),   32'h0);
    chk("exp_pre_send", 32'(Tx_Send), 32'h1);
    force_busy = 1'b1;
    step();
    chk("exp_ack", 32'(Req_Ack), 32'h1);
    chk("exp_err", 32'(Error),   32'h0);
    force_busy = 1'b0;
    step();
    step();
    step();
    chk("exp_grant_clr", 32'(Grant), 32'h0);
    chk("exp_no_err",    32'(err_cnt - base_err), 32'd0);

    // Reset while in WAIT_IDLE, with the pointer already advanced to 1.
    mdl_en    = 1'b1;
    Req_Data  = 32'h0000_4400;
    Req_Valid = 4'b0010;
    cnt = 0;
    while (Req_Ack == '0 && cnt < 30) begin
      step();
      cnt++;
    end
    chk("rm_acked", 32'(cnt < 30), 32'd1);
    Req_Valid = '0;
    do_reset();
    chk("rm_grant", 32'(Grant),   32'h0);
    chk("rm_send",  32'(Tx_Send), 32'h0);
    chk("rm_data",  32'(Tx_Data), 32'h0);
    chk("rm_ack",   32'(Req_Ack), 32'h0);
    chk("rm_err",   32'(Error),   32'h0);
    chk("rm_ptr",   32'(dut.ptr_q), 32'h0);

    // Fresh request from requester 2 while the transmitter is still finishing; data changes after grant.
    base_ack  = ack_cnt[2];
    Req_Data  = 32'h005A_0000;
    Req_Valid = 4'b0100;
    step();
    chk("busy_idle_nosend", 32'(Tx_Send), 32'h0);
    cnt = 0;
    while (Tx_Send !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("r2_grant", 32'(Grant),   32'h4);
    chk("r2_data",  32'(Tx_Data), 32'h5A);
    Req_Data = 32'h00FF_0000;
    bad = 0;
    cnt = 0;
    while (!(Grant == '0 && Req_Valid == '0) && cnt < 60) begin
      step();
      if (Grant != '0 && Tx_Data !== 8'h5A) bad++;
      cnt++;
    end
    chk("r2_drain",      32'(cnt < 60), 32'd1);
    chk("r2_stable",     32'(bad),      32'd0);
    step();
    chk("r2_ack_once",   32'(ack_cnt[2] - base_ack), 32'd1);
    chk("r2_frame",      32'(m_frame),  32'(10'b1_0101_1010_0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
